iir_decimator: RTL and testbench
================================

Name: iir_decimator

Overview:
- Downstream stage of the biquad IIR filter: consumes its N-bit signed output stream, block-averages R = 2^LOG2_R consecutive samples and emits one rounded, saturated average per block.
- Output buffered in a small FIFO with valid/ready handshake toward slower consumers (packetiser, host readout).
- Upstream cannot be stalled; loss under backpressure is flagged, never silent.

Parameters:
- N, 16, sample width (input and output), signed two's complement
- LOG2_R, 2, log2 of decimation factor R; legal 0..8
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_data carries a sample this cycle
- in_data  in  N  signed filtered sample
- out_valid  out  1  FIFO non-empty; out_data valid
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  N  signed decimated sample (FIFO head)
- overflow  out  1  sticky: a decimated result was dropped (FIFO full)
- clear_ovf  in  1  clears overflow
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (sync): acc=0, phase=0, FIFO empty (rd/wr pointers 0), out_valid=0, out_data=0, overflow=0, level=0. rst mid-block discards partial accumulation and all buffered results; rst overrides every other input.
- Input always accepted when in_valid=1 (no ready). in_valid=0 cycles: acc and phase hold; gaps of any length allowed.
- Accumulator: signed, N+LOG2_R bits, cannot overflow. phase counter 0..R-1.
- Sample accepted with phase<R-1: acc<=acc+in_data, phase<=phase+1.
- Sample accepted with phase==R-1 (block end): sum=acc+in_data (combinational); acc<=0, phase<=0.
- Result: LOG2_R=0 -> res=sum; else res=(sum + 2^(LOG2_R-1)) >>> LOG2_R (arithmetic shift; round half toward +inf). Clamp res to [-(2^(N-1)), 2^(N-1)-1], take N bits.
- Push: res written into FIFO on the block-end edge. With FIFO previously empty, out_valid=1 and out_data=res in the next cycle (latency 1 clock after R-th sample edge).
- Pop: out_valid && out_ready on an edge advances the head; out_data presents the next entry the following cycle. out_data holds stable while out_valid=1 and out_ready=0.
- Full FIFO, push with simultaneous pop: both occur, nothing lost, level unchanged.
- Full FIFO, push without pop: result dropped, FIFO untouched, overflow<=1. Accumulator still restarts (block boundaries never slip).
- Empty FIFO: out_ready ignored, no pop, pointers unchanged.
- Pointers: log2(FIFO_DEPTH)-bit wrap-around; level = push/pop count difference, range 0..FIFO_DEPTH.
- overflow: set by drop, cleared by clear_ovf; same-cycle drop and clear_ovf -> overflow=1 (set wins).
- out_data when out_valid=0: holds last value (0 after reset); consumers must not sample it.

Test Plan:
- N=16, LOG2_R=2: in 100,200,300,400 consecutive, out_ready=1 -> out_valid=1 one cycle after 4th sample, out_data=250, level returns to 0 after pop.
- Negative rounding: -1,-2,-2,-2 -> sum -7, out_data=-2; then 1,1,0,0 -> out_data=1 (0.5 rounds up).
- Full scale: four 32767 -> 32767; four -32768 -> -32768; no wrap.
- Gaps: 10, three idle cycles, 20, idle, 30, 40 -> out_data=25, exactly one output.
- Backpressure, out_ready=0: five blocks of constant 8,16,24,32,40 -> level=4, overflow=1 after 5th block; out_ready=1 drains 8,16,24,32 in order, 40 never appears; clear_ovf pulse -> overflow=0; drop coinciding with clear_ovf leaves overflow=1. Full FIFO with out_ready=1 at a push -> no drop, level stays 4.
- Reset mid-operation: samples 1000,1000, rst one cycle, then four samples of 8 -> single output 8, FIFO and overflow cleared by rst.

Source files
------------

// File: rtl/iir_decimator.sv
// Block-average decimator behind the biquad IIR: averages 2^LOG2_R samples,
// rounds, saturates and queues each result in a small output FIFO.
module iir_decimator #(
  parameter int N          = 16,
  parameter int LOG2_R     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [N-1:0]                  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N-1:0]                  out_data,
  output logic                          overflow,
  input  logic                          clear_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int R    = 1 << LOG2_R;
  localparam int ACCW = N + LOG2_R;
  localparam int PW   = (LOG2_R > 0) ? LOG2_R : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;

  localparam logic signed [ACCW:0] MAXV =
    {{(LOG2_R+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACCW:0] MINV =
    {{(LOG2_R+2){1'b1}}, {(N-1){1'b0}}};
  localparam logic signed [ACCW:0] RND = (ACCW+1)'(R / 2);

  logic signed [ACCW-1:0] acc;
  logic [PW-1:0]          phase;
  logic signed [ACCW:0]   sum;
  logic signed [ACCW:0]   rnd;
  logic signed [ACCW:0]   shf;
  logic [N-1:0]           res;

  logic [N-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [LW-1:0] cnt;

  logic last;
  logic blk_end;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign sum = {acc[ACCW-1], acc}
             + {{(LOG2_R+1){in_data[N-1]}}, in_data};
  assign rnd = sum + RND;
  assign shf = rnd >>> LOG2_R;

  always_comb begin
    res = shf[N-1:0];
    if (shf > MAXV)
      res = MAXV[N-1:0];
    else if (shf < MINV)
      res = MINV[N-1:0];
  end

  assign last    = (phase == PW'(R - 1));
  assign blk_end = in_valid && last;
  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(FIFO_DEPTH));
  assign pop     = !empty && out_ready;
  assign push    = blk_end && (!full || pop);
  assign drop    = blk_end && full && !pop;
  assign rd_nxt  = rd_ptr + 1'b1;

  assign out_valid = !empty;
  assign level     = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      phase <= '0;
    end else if (in_valid) begin
      if (last) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= sum[ACCW-1:0];
        phase <= phase + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_nxt;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Registered head so out_data keeps its last value once the FIFO drains.
  always_ff @(posedge clk) begin
    if (rst)
      out_data <= '0;
    else if (pop && cnt > LW'(1))
      out_data <= mem[rd_nxt];
    else if (push && (empty || (pop && cnt == LW'(1))))
      out_data <= res;
  end

  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clear_ovf)
      overflow <= 1'b0;
  end

endmodule

// File: tb/tb_iir_decimator.sv
// Bench for iir_decimator: directed scenarios plus random traffic checked
// against a queue-based averaging model.
module tb_iir_decimator;

  localparam int N     = 16;
  localparam int L2R   = 2;
  localparam int R     = 1 << L2R;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [N-1:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [N-1:0] out_data;
  logic        overflow;
  logic        clear_ovf;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  int m_sum;
  int m_n;
  int mq[$];
  bit m_ovf;

  iir_decimator #(.N(N), .LOG2_R(L2R), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .overflow(overflow), .clear_ovf(clear_ovf), .level(level)
  );

  always #5 clk = ~clk;

  function automatic int avg(input int s);
    int v;
    v = int'($floor(real'(s) / R + 0.5));
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic drive(input bit iv, input int d, input bit rdy,
                       input bit clr, input bit r);
    bit pop;
    bit blk;
    bit drop;
    int res;
    in_valid = iv;
    in_data = 16'(d);
    out_ready = rdy;
    clear_ovf = clr;
    rst = r;
    @(posedge clk);
    res = 0;
    blk = 0;
    drop = 0;
    if (r) begin
      m_sum = 0;
      m_n = 0;
      mq.delete();
      m_ovf = 0;
    end else begin
      pop = (mq.size() > 0) && rdy;
      if (iv) begin
        m_sum += d;
        m_n++;
        if (m_n == R) begin
          res = avg(m_sum);
          m_sum = 0;
          m_n = 0;
          blk = 1;
        end
      end
      if (pop) void'(mq.pop_front());
      if (blk) begin
        if (mq.size() < DEPTH) mq.push_back(res);
        else begin
          drop = 1;
          m_ovf = 1;
        end
      end
      if (clr && !drop) m_ovf = 0;
    end
    #1;
  endtask

  task automatic block(input int v, input bit rdy);
    for (int i = 0; i < R; i++) drive(1, v, rdy, 0, 0);
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL reset_empty: valid=%b level=%0d want 0/0",
               out_valid, level);
    end
    checks++;
    if (out_data !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: data=%0d ovf=%b want 0/0",
               $signed(out_data), overflow);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_basic;
    int vals[4] = '{100, 200, 300, 400};
    for (int i = 0; i < 4; i++) drive(1, vals[i], 1, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || $signed(out_data) !== 16'sd250) begin
      errors++;
      $display("FAIL basic_avg: valid=%b data=%0d want 1/250",
               out_valid, $signed(out_data));
    end
    drive(0, 0, 1, 0, 0);
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pop: level=%0d valid=%b want 0/0",
               level, out_valid);
    end
  endtask

  task automatic test_rounding;
    int a[4] = '{-1, -2, -2, -2};
    int b[4] = '{1, 1, 0, 0};
    for (int i = 0; i < 4; i++) drive(1, a[i], 0, 0, 0);
    checks++;
    if ($signed(out_data) !== -16'sd2) begin
      errors++;
      $display("FAIL round_neg: got %0d want -2", $signed(out_data));
    end
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, b[i], 0, 0, 0);
    checks++;
    if ($signed(out_data) !== 16'sd1 || level !== 3'd1) begin
      errors++;
      $display("FAIL round_half: got %0d level %0d want 1/1",
               $signed(out_data), level);
    end
    drive(0, 0, 1, 0, 0);
  endtask

  task automatic test_full_scale;
    block(32767, 0);
    checks++;
    if ($signed(out_data) !== 16'sd32767) begin
      errors++;
      $display("FAIL full_pos: got %0d want 32767", $signed(out_data));
    end
    drive(0, 0, 1, 0, 0);
    block(-32768, 0);
    checks++;
    if ($signed(out_data) !== -16'sd32768) begin
      errors++;
      $display("FAIL full_neg: got %0d want -32768", $signed(out_data));
    end
    drive(0, 0, 1, 0, 0);
  endtask

  task automatic test_gaps;
    int early = 0;
    drive(1, 10, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0);
      if (out_valid) early++;
    end
    drive(1, 20, 1, 0, 0);
    if (out_valid) early++;
    drive(0, 0, 1, 0, 0);
    if (out_valid) early++;
    drive(1, 30, 1, 0, 0);
    if (out_valid) early++;
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL gaps_early: %0d early valid cycles want 0", early);
    end
    drive(1, 40, 1, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || $signed(out_data) !== 16'sd25) begin
      errors++;
      $display("FAIL gaps_avg: valid=%b data=%0d want 1/25",
               out_valid, $signed(out_data));
    end
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL gaps_single: valid=%b level=%0d want 0/0",
               out_valid, level);
    end
  endtask

  task automatic test_backpressure;
    for (int b = 1; b <= 5; b++) block(8 * b, 0);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: level=%0d ovf=%b want 4/1", level, overflow);
    end
    for (int b = 1; b <= 4; b++) begin
      checks++;
      if (out_valid !== 1'b1 || $signed(out_data) !== 16'(8 * b)) begin
        errors++;
        $display("FAIL bp_drain%0d: valid=%b data=%0d want 1/%0d",
                 b, out_valid, $signed(out_data), 8 * b);
      end
      drive(0, 0, 1, 0, 0);
    end
    checks++;
    if (out_valid !== 1'b0 || $signed(out_data) !== 16'sd32) begin
      errors++;
      $display("FAIL bp_empty: valid=%b data=%0d want 0/32",
               out_valid, $signed(out_data));
    end
    drive(0, 0, 0, 1, 0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_clear: ovf=%b want 0", overflow);
    end
    for (int b = 0; b < 4; b++) block(b, 0);
    for (int i = 0; i < R - 1; i++) drive(1, 5, 0, 0, 0);
    drive(1, 5, 0, 1, 0);
    checks++;
    if (overflow !== 1'b1 || level !== 3'd4) begin
      errors++;
      $display("FAIL bp_set_wins: ovf=%b level=%0d want 1/4",
               overflow, level);
    end
    for (int i = 0; i < R - 1; i++) drive(1, 7, 0, 0, 0);
    drive(1, 7, 1, 1, 0);
    checks++;
    if (overflow !== 1'b0 || level !== 3'd4 ||
        $signed(out_data) !== 16'sd1) begin
      errors++;
      $display("FAIL bp_push_pop: ovf=%b level=%0d data=%0d want 0/4/1",
               overflow, level, $signed(out_data));
    end
    block(9, 0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_reset_prep: ovf=%b want 1", overflow);
    end
  endtask

  task automatic test_mid_reset;
    drive(1, 1000, 0, 0, 0);
    drive(1, 1000, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    checks++;
    if (level !== 3'd0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_clear: level=%0d ovf=%b valid=%b want 0/0/0",
               level, overflow, out_valid);
    end
    block(8, 0);
    checks++;
    if (level !== 3'd1 || $signed(out_data) !== 16'sd8) begin
      errors++;
      $display("FAIL rst_restart: level=%0d data=%0d want 1/8",
               level, $signed(out_data));
    end
    drive(0, 0, 1, 0, 0);
  endtask

  task automatic test_random;
    int d;
    bit iv;
    bit rdy;
    int bad = 0;
    drive(0, 0, 0, 0, 1);
    for (int c = 0; c < 1500; c++) begin
      iv = ($urandom % 4) != 0;
      d = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom % 6 == 0) d = ($urandom % 2) ? 32767 : -32768;
      rdy = ((c / 100) % 2) ? ($urandom % 2 == 0) : ($urandom % 6 == 0);
      drive(iv, d, rdy, ($urandom % 25) == 0, 0);
      checks++;
      if (out_valid !== (mq.size() > 0) || level !== 3'(mq.size()) ||
          overflow !== m_ovf) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_state@%0d: v=%b lvl=%0d ovf=%b want %0d/%0d/%b",
                   c, out_valid, level, overflow, mq.size() > 0,
                   mq.size(), m_ovf);
      end
      if (mq.size() > 0) begin
        checks++;
        if ($signed(out_data) !== 16'(mq[0])) begin
          errors++;
          bad++;
          if (bad < 10)
            $display("FAIL rand_data@%0d: got %0d want %0d",
                     c, $signed(out_data), mq[0]);
        end
      end
    end
  endtask

  initial begin
    m_sum = 0;
    m_n = 0;
    m_ovf = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_full_scale();
    test_gaps();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
